// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the cache/memory arbiter and the caches that talk to it.
// Grant ids index the two-bit request/grant vectors: bit 0 = I-cache, bit 1 = D-cache.
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int GRANT_I = 0;
    localparam int GRANT_D = 1;

    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_DATA_W     = 32;

    // Number of address bits inside one memory beat.
    function automatic int byte_off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Number of address bits inside one cache line.
    function automatic int line_off_w(input int data_w, input int line_words);
        return $clog2(line_words) + byte_off_w(data_w);
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// Two-input round-robin picker. On a tie it grants the requester that was not served last;
// the last-served id only moves when a grant is actually issued.
module cache_mem_arbiter_rr_arb2
    import cache_mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    logic last_grant;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Reset to D so the I-cache wins the very first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
        end else if (|gnt) begin
            last_grant <= gnt[GRANT_D];
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one external memory port between the I- and D-cache miss engines, sequencing one
// line-sized burst per grant and freezing the pipeline while any miss is outstanding.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ic_req,
    input  logic [ADDR_W-1:0]             ic_addr,
    output logic                          ic_rvalid,
    output logic                          ic_done,
    input  logic                          dc_req,
    input  logic                          dc_we,
    input  logic [ADDR_W-1:0]             dc_addr,
    input  logic [DATA_W-1:0]             dc_wdata,
    output logic                          dc_rvalid,
    output logic                          dc_done,
    output logic [$clog2(LINE_WORDS)-1:0] beat_idx,
    output logic [DATA_W-1:0]             rdata,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_ready,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          stall_cache
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int BYTE_W = byte_off_w(DATA_W);
    localparam int OFF_W  = line_off_w(DATA_W, LINE_WORDS);

    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFF_W) - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    arb_state_t          state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                we_q, we_d;
    logic                owner_q, owner_d;
    logic [1:0]          gnt;
    logic                in_burst;
    logic                beat_last;

    // Arbitration only happens between bursts, so late requests wait without preempting.
    cache_mem_arbiter_rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .req    ({dc_req, ic_req}),
        .enable (state_q == IDLE),
        .gnt    (gnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            we_q    <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            we_q    <= we_d;
            owner_q <= owner_d;
        end
    end

    assign in_burst  = (state_q == GNT_I) || (state_q == GNT_D);
    assign beat_last = (beat_q == LAST_BEAT);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        we_d    = we_q;
        owner_d = owner_q;
        unique case (state_q)
            IDLE: begin
                if (gnt[GRANT_I]) begin
                    state_d = GNT_I;
                    base_d  = ic_addr & LINE_MASK;
                    we_d    = 1'b0;
                    owner_d = 1'(GRANT_I);
                    beat_d  = '0;
                end else if (gnt[GRANT_D]) begin
                    state_d = GNT_D;
                    base_d  = dc_addr & LINE_MASK;
                    we_d    = dc_we;
                    owner_d = 1'(GRANT_D);
                    beat_d  = '0;
                end
            end
            GNT_I, GNT_D: begin
                // A stalled beat (mem_ready low) keeps beat, address and data frozen.
                if (mem_ready) begin
                    if (beat_last) begin
                        state_d = DONE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_req   = in_burst;
        mem_we    = in_burst & we_q;
        mem_addr  = '0;
        mem_wdata = '0;
        ic_rvalid = 1'b0;
        dc_rvalid = 1'b0;
        ic_done   = 1'b0;
        dc_done   = 1'b0;
        if (in_burst) begin
            mem_addr = base_q + (ADDR_W'(beat_q) << BYTE_W);
        end
        if ((state_q == GNT_D) && we_q) begin
            mem_wdata = dc_wdata;
        end
        if ((state_q == GNT_I) && !we_q) begin
            ic_rvalid = mem_ready;
        end
        if ((state_q == GNT_D) && !we_q) begin
            dc_rvalid = mem_ready;
        end
        if (state_q == DONE) begin
            ic_done = (owner_q == 1'(GRANT_I));
            dc_done = (owner_q == 1'(GRANT_D));
        end
    end

    assign beat_idx = beat_q;
    assign rdata    = mem_rdata;

    // Drops in the done cycle so the pipeline advances as the last beat lands.
    assign stall_cache = (ic_req & ~ic_done) | (dc_req & ~dc_done);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a per-cycle vector table plus a hand-written
// reset-mid-burst sequence.
module tb_cache_mem_arbiter;
    import cache_mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ic_req = 1'b0;
    logic [31:0] ic_addr = '0;
    logic        ic_rvalid, ic_done;
    logic        dc_req = 1'b0;
    logic        dc_we = 1'b0;
    logic [31:0] dc_addr = '0;
    logic [31:0] dc_wdata;
    logic        dc_rvalid, dc_done;
    logic [1:0]  beat_idx;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata;
    logic        stall_cache;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory returns 0xA0+beat; D-cache presents 0xD000_0000+beat as write-back data.
    assign mem_rdata = 32'hA0 + {30'b0, beat_idx};
    assign dc_wdata  = 32'hD000_0000 + {30'b0, beat_idx};

    cache_mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .ic_req      (ic_req),
        .ic_addr     (ic_addr),
        .ic_rvalid   (ic_rvalid),
        .ic_done     (ic_done),
        .dc_req      (dc_req),
        .dc_we       (dc_we),
        .dc_addr     (dc_addr),
        .dc_wdata    (dc_wdata),
        .dc_rvalid   (dc_rvalid),
        .dc_done     (dc_done),
        .beat_idx    (beat_idx),
        .rdata       (rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .stall_cache (stall_cache)
    );

    typedef struct {
        logic        ic_req;
        logic [31:0] ic_addr;
        logic        dc_req;
        logic        dc_we;
        logic [31:0] dc_addr;
        logic        rdy;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [1:0]  e_beat;
        logic        e_irv;
        logic        e_idone;
        logic        e_drv;
        logic        e_ddone;
        logic        e_stall;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] cur_ia = '0;
    logic [31:0] cur_da = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic ic, input logic dc, input logic we, input logic rdy,
                        input logic e_req, input logic e_we, input logic [31:0] e_addr,
                        input int e_beat, input logic irv, input logic idone,
                        input logic drv, input logic ddone, input logic stall);
        vec_t r;
        r.ic_req = ic;      r.ic_addr = cur_ia;
        r.dc_req = dc;      r.dc_we   = we;     r.dc_addr = cur_da;
        r.rdy    = rdy;
        r.e_req  = e_req;   r.e_we    = e_we;   r.e_addr  = e_addr;
        r.e_beat = 2'(e_beat);
        r.e_irv  = irv;     r.e_idone = idone;
        r.e_drv  = drv;     r.e_ddone = ddone;  r.e_stall = stall;
        tbl.push_back(r);
    endtask

    // Four back-to-back read beats from a line base, mem_ready always high.
    task automatic burst(input logic ic, input logic dc, input logic d_owner, input logic [31:0] base);
        for (int b = 0; b < 4; b++) begin
            push(ic, dc, 1'b0, 1'b1, 1'b1, 1'b0, base + 32'(4 * b), b,
                 !d_owner, 1'b0, d_owner, 1'b0, 1'b1);
        end
    endtask

    task automatic idle_row(input logic ic, input logic dc);
        push(ic, dc, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0, ic | dc);
    endtask

    task automatic apply_row(input int idx, input vec_t r);
        @(posedge clk);
        #1;
        ic_req    = r.ic_req;
        ic_addr   = r.ic_addr;
        dc_req    = r.dc_req;
        dc_we     = r.dc_we;
        dc_addr   = r.dc_addr;
        mem_ready = r.rdy;
        @(negedge clk);
        chk($sformatf("row%0d mem_req", idx),     32'(mem_req),     32'(r.e_req));
        chk($sformatf("row%0d mem_we", idx),      32'(mem_we),      32'(r.e_we));
        chk($sformatf("row%0d mem_addr", idx),    mem_addr,         r.e_addr);
        chk($sformatf("row%0d beat_idx", idx),    32'(beat_idx),    32'(r.e_beat));
        chk($sformatf("row%0d mem_wdata", idx),   mem_wdata,
            r.e_we ? 32'hD000_0000 + 32'(r.e_beat) : 32'h0);
        chk($sformatf("row%0d rdata", idx),       rdata,            32'hA0 + 32'(r.e_beat));
        chk($sformatf("row%0d ic_rvalid", idx),   32'(ic_rvalid),   32'(r.e_irv));
        chk($sformatf("row%0d ic_done", idx),     32'(ic_done),     32'(r.e_idone));
        chk($sformatf("row%0d dc_rvalid", idx),   32'(dc_rvalid),   32'(r.e_drv));
        chk($sformatf("row%0d dc_done", idx),     32'(dc_done),     32'(r.e_ddone));
        chk($sformatf("row%0d stall_cache", idx), 32'(stall_cache), 32'(r.e_stall));
    endtask

    initial begin
        // Both idle for 10 cycles.
        for (int i = 0; i < 10; i++) idle_row(1'b0, 1'b0);

        // Tie straight after reset: I first, then D after the I DONE + IDLE cycle.
        cur_ia = 32'h0000_0100; cur_da = 32'h0000_0300;
        idle_row(1'b1, 1'b1);
        burst(1'b1, 1'b1, 1'b0, 32'h0000_0100);
        push(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle_row(1'b0, 1'b1);
        burst(1'b0, 1'b1, 1'b1, 32'h0000_0300);
        push(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_row(1'b0, 1'b0);

        // D write-back with ready pattern 1,0,0,1,1,1; dc_we drops mid-burst but stays latched.
        cur_da = 32'h0000_2000;
        push(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_2000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_2004, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_2004, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_2004, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_2008, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_200C, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_row(1'b0, 1'b0);

        // I fill alone from an unaligned address.
        cur_ia = 32'h0000_1234;
        idle_row(1'b1, 1'b0);
        burst(1'b1, 1'b0, 1'b0, 32'h0000_1230);
        push(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_row(1'b0, 1'b0);

        // Tie again with I served last: D first, then I.
        cur_ia = 32'h0000_0100; cur_da = 32'h0000_0300;
        idle_row(1'b1, 1'b1);
        burst(1'b1, 1'b1, 1'b1, 32'h0000_0300);
        push(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_row(1'b1, 1'b0);
        burst(1'b1, 1'b0, 1'b0, 32'h0000_0100);
        push(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_row(1'b0, 1'b0);

        // D request rises on beat 1 of an I burst: no preemption, stall held throughout.
        cur_ia = 32'h0000_0400; cur_da = 32'h0000_0500;
        idle_row(1'b1, 1'b0);
        push(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0400, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int b = 1; b < 4; b++) begin
            push(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0400 + 32'(4 * b), b,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        push(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle_row(1'b0, 1'b1);
        burst(1'b0, 1'b1, 1'b1, 32'h0000_0500);
        push(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_row(1'b0, 1'b0);

        // Reset state.
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset mem_req",  32'(mem_req),     32'h0);
        chk("reset state",    32'(dut.state_q), 32'(IDLE));
        chk("reset beat_idx", 32'(beat_idx),    32'h0);
        chk("reset stall",    32'(stall_cache), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply_row(i, tbl[i]);

        // Reset at beat 2 of a D fill, then restart with dc_req still high.
        @(posedge clk);
        #1;
        ic_req = 1'b0; dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_3008; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rmb b0 mem_addr", mem_addr, 32'h0000_3000);
        repeat (2) @(posedge clk);
        #1;
        chk("rmb b2 beat_idx", 32'(beat_idx), 32'h2);
        chk("rmb b2 mem_req",  32'(mem_req),  32'h1);
        rst = 1'b0;
        #1;
        chk("rmb rst mem_req",   32'(mem_req),     32'h0);
        chk("rmb rst dc_done",   32'(dc_done),     32'h0);
        chk("rmb rst dc_rvalid", 32'(dc_rvalid),   32'h0);
        chk("rmb rst state",     32'(dut.state_q), 32'(IDLE));
        chk("rmb rst beat_idx",  32'(beat_idx),    32'h0);
        chk("rmb rst stall",     32'(stall_cache), 32'h1);
        @(posedge clk);
        #1;
        chk("rmb hold dc_done", 32'(dc_done), 32'h0);
        chk("rmb hold mem_req", 32'(mem_req), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rmb restart mem_req",  32'(mem_req),  32'h1);
        chk("rmb restart mem_addr", mem_addr,      32'h0000_3000);
        chk("rmb restart beat_idx", 32'(beat_idx), 32'h0);
        chk("rmb restart rvalid",   32'(dc_rvalid), 32'h1);
        chk("rmb restart rdata",    rdata,         32'h0000_00A0);
        repeat (3) @(posedge clk);
        #1;
        chk("rmb b3 mem_addr", mem_addr, 32'h0000_300C);
        @(posedge clk);
        #1;
        chk("rmb done dc_done", 32'(dc_done), 32'h1);
        chk("rmb done mem_req", 32'(mem_req), 32'h0);
        chk("rmb done stall",   32'(stall_cache), 32'h0);
        @(posedge clk);
        #1;
        dc_req = 1'b0;
        @(negedge clk);
        chk("rmb end dc_done", 32'(dc_done),     32'h0);
        chk("rmb end stall",   32'(stall_cache), 32'h0);
        chk("rmb end mem_req", 32'(mem_req),     32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single external memory port between the I-cache and D-cache miss engines.
- Sequences line-sized bursts for each requester.
- Drives the `stall_cache` input of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) while any miss is outstanding.
- Sits between the two caches and the memory/bus interface.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width of one memory beat.
- LINE_WORDS, 4, beats per cache line; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-low
- ic_req  input  1  I-cache line-fill request; held until ic_done
- ic_addr  input  ADDR_W  I-cache miss address; low log2(LINE_WORDS)+2 bits ignored
- ic_rvalid  output  1  fill beat valid for I-cache
- ic_done  output  1  one-cycle pulse, I-cache transaction complete
- dc_req  input  1  D-cache request; held until dc_done
- dc_we  input  1  1 = line write-back, 0 = line fill; sampled at grant
- dc_addr  input  ADDR_W  D-cache line address; low bits ignored
- dc_wdata  input  DATA_W  write-back data for current beat_idx (combinational from D-cache)
- dc_rvalid  output  1  fill beat valid for D-cache
- dc_done  output  1  one-cycle pulse, D-cache transaction complete
- beat_idx  output  log2(LINE_WORDS)  current beat index, shared by both caches
- rdata  output  DATA_W  fill data, wired from mem_rdata
- mem_req  output  1  memory beat request
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  beat address
- mem_wdata  output  DATA_W  beat write data
- mem_ready  input  1  memory accepted/returned current beat this cycle
- mem_rdata  input  DATA_W  memory read data, valid when mem_ready
- stall_cache  output  1  pipeline freeze request

Behaviour:
- States: IDLE, GNT_I, GNT_D, DONE. Registers: state, beat counter, latched base address, latched we, last_grant (0 = I, 1 = D).
- Reset (rst low, asynchronous):
  - state = IDLE, beat = 0, last_grant = 1 (so I-cache wins the first tie).
  - All outputs 0, except stall_cache, which follows the combinational rule below.
  - Reset mid-burst abandons the burst: mem_req drops immediately, no done pulse.
- IDLE:
  - Only dc_req: go to GNT_D next cycle.
  - Only ic_req: go to GNT_I next cycle.
  - Both: grant the requester that is not last_grant (round-robin).
  - On grant, latch the line-aligned base address and we (dc_we for D, 0 for I); set beat = 0; update last_grant.
  - Grant latency is one cycle from request to the first mem_req.
- GNT_x:
  - mem_req = 1.
  - mem_addr = base + beat*(DATA_W/8).
  - mem_we = latched we; mem_wdata = dc_wdata when D write, else 0.
  - Each cycle with mem_ready = 1 completes one beat and beat increments.
  - On a read, x_rvalid = mem_ready, with rdata and beat_idx valid in the same cycle.
  - mem_ready = 0 holds the beat, address and data unchanged; there is no timeout.
  - When the beat with beat = LINE_WORDS-1 completes, go to DONE and wrap beat to 0.
- DONE:
  - Exactly one cycle; x_done = 1 for the granted requester only; mem_req = 0; then return to IDLE.
  - The requester drops req in the cycle after done. A new req therefore has at least one idle cycle before its grant.
- stall_cache (combinational) = (ic_req & ~ic_done) | (dc_req & ~dc_done).
  - It is 0 in the done cycle, so the pipeline advances as the data lands.
  - The pipeline register's own stall input overrides stall_cache.
- Requests arriving during a burst are held pending. They do not preempt, and are arbitrated in IDLE.
- A requester deasserting req mid-burst is illegal. The burst still completes and the done pulse is still issued.
- With LINE_WORDS*(DATA_W/8) alignment, addresses never cross a line.

Decomposition:
- Shared package:
  - State encoding enum (IDLE=0, GNT_I=1, GNT_D=2, DONE=3).
  - Grant-id constants GRANT_I/GRANT_D.
  - Default LINE_WORDS and byte-offset width constants, reused by both caches.
- One sub-module is natural: rr_arb2, a 2-input round-robin picker holding last_grant, with inputs req[1:0] and enable, and outputs gnt[1:0].
- Burst sequencing stays in the top module.

Test Plan:
- I-fill alone:
  - Stimulus: ic_req=1, ic_addr=0x0000_1234, mem_ready always 1, mem_rdata = 0xA0+beat.
  - Required: mem_addr 0x1230, 0x1234, 0x1238, 0x123C on 4 consecutive cycles; ic_rvalid on each with rdata 0xA0..0xA3.
  - Required: ic_done on cycle 6 after req; stall_cache 1 for cycles 1-5, 0 on cycle 6.
- D write-back with waits:
  - Stimulus: dc_req=1, dc_we=1, dc_addr=0x2000, mem_ready pattern 1,0,0,1,1,1.
  - Required: mem_we=1; mem_addr holds 0x2004 for 3 cycles; mem_wdata tracks dc_wdata(beat_idx); dc_done once after the 4th accepted beat; no dc_rvalid.
- Simultaneous requests after reset:
  - Stimulus: ic_req and dc_req both rise on the same cycle.
  - Required: I granted first (last_grant reset = D); D granted after the I DONE + IDLE cycle.
  - Required: repeating the tie gives the D-first, I-next order.
- Request during burst:
  - Stimulus: dc_req rises on beat 1 of an I burst.
  - Required: no preemption; D granted in the IDLE cycle following ic_done; stall_cache stays 1 throughout.
- Reset mid-burst:
  - Stimulus: rst low at beat 2 of a D fill.
  - Required: mem_req=0 immediately, no dc_done, state IDLE; after rst high with dc_req still 1, a fresh burst restarts at beat 0.
- Both idle:
  - Stimulus: no requests for 10 cycles.
  - Required: mem_req, stall_cache, done and rvalid outputs all 0.
